int_regfile_sb: RTL and testbench
=================================

# int_regfile_sb

Integer register file with a per-register pending-write scoreboard. It sits between `dec_reg_latch` and `reg_exe_latch`:
- It consumes the latched read addresses, destination address and write enable of the instruction in the register stage.
- It supplies 64-bit operands to `reg_exe_latch`.
- It accepts the writeback port from the end of the pipe.
- It raises a stall when an operand or destination still has an outstanding writeback.

## Interface
Reset is asynchronous and active-low on `reset`; the clock is `clock`.

Parameters:
- `DATA_W`, 64, operand and writeback data width
- `ADDR_W`, 5, register address width
- `NREGS`, 32, number of architectural registers; register 0 is hardwired to zero

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `reg_issue_valid`  in  1  a valid instruction occupies the register stage
- `reg_read_addr_a`  in  ADDR_W  source A address
- `reg_read_addr_b`  in  ADDR_W  source B address
- `reg_write_addr`  in  ADDR_W  destination of the issuing instruction
- `reg_int_write_enable`  in  1  issuing instruction writes `reg_write_addr`
- `wb_write_enable`  in  1  writeback strobe
- `wb_write_addr`  in  ADDR_W  writeback address
- `wb_write_data`  in  DATA_W  writeback data
- `reg_int_data_a`  out  DATA_W  source A operand
- `reg_int_data_b`  out  DATA_W  source B operand
- `reg_stall`  out  1  instruction cannot issue; the upstream latch must hold
- `reg_pending`  out  NREGS  scoreboard busy bits (bit 0 always 0)

## Operation
- **Read ports:** combinational lookup of `reg_read_addr_a` and `reg_read_addr_b`. Address 0 returns 0 regardless of array contents.
- **Writeback:** on the rising edge, if `wb_write_enable` is set and `wb_write_addr` is not 0, the array entry is written. Writes to address 0 are discarded. Writeback to a non-busy register is legal: data is written and the scoreboard is unchanged.
- **Hazard terms:**
  - `hazA` = `busy[addr_a]` and `addr_a` != 0
  - `hazB` = `busy[addr_b]` and `addr_b` != 0
  - `hazW` = `reg_int_write_enable` and `busy[dest]` and `dest` != 0 (WAW)
- **Stall:** `reg_stall` = `reg_issue_valid` and (`hazA` or `hazB` or `hazW`).
- **Issue:** an issue is accepted when `reg_issue_valid` is set and `reg_stall` is clear. On the edge of an accepted issue with a write enable and `dest` != 0, `busy[dest]` is set.
- **Clear:** on the edge where a writeback occurs with `wb_write_addr` != 0, `busy[wb_write_addr]` is cleared.
- **Simultaneous set and clear** of the same register on one edge: set wins, because a new producer is in flight.
- **Stall inactive:** with `reg_issue_valid` low, `reg_stall` is 0 and no busy bit is set.
- **Reset values:** all array entries 0 and all busy bits 0. Consequently `reg_pending` = 0, `reg_stall` = 0, and both data outputs = 0 for any address.

## Timing
- Read latency is 0 cycles. Operands are valid in the same cycle as the addresses, and `reg_exe_latch` captures them on the next edge.
- Writeback becomes architecturally visible on the cycle after `wb_write_enable`.
- A busy bit is set or cleared at the edge and is visible in `reg_pending`, and in stall evaluation, from the following cycle.
- `reg_stall` is combinational from the current inputs and the busy bits; there is no registered stall.
- Reset asserted mid-operation clears the array and scoreboard immediately, without waiting for a clock edge. Pending writebacks arriving after reset release are written to the array but set no busy bit.

## Configuration
- **`REGFILE_BYPASS_EN` defined:**
  - A same-cycle writeback is forwarded to the outputs. When `wb_write_enable` is set, `wb_write_addr` equals a read address, and that address is not 0, the corresponding output returns `wb_write_data`.
  - The matching `hazA`, `hazB` or `hazW` term is masked in that cycle, so the instruction issues without waiting.
  - With an accepted WAW-masked issue, set wins and the busy bit stays 1.
- **`REGFILE_BYPASS_EN` undefined:**
  - No forwarding; outputs reflect array contents only.
  - A consumer stalls through the writeback cycle and issues on the following cycle.

## Structure
- **Shared package `vi_core_pkg`:** `DATA_W`, `ADDR_W` and `NREGS` constants, the `reg_addr_t` and `xlen_data_t` typedefs, and the `ZERO_REG` constant.
- **Sub-module `int_scoreboard`:** holds the busy vector, the set/clear priority logic and the hazard/stall computation.
- **Top level:** holds the array, the read muxes and the bypass muxes.

## Test plan
- **Reset:** assert `reset` = 0 with `addr_a` = 5 and `addr_b` = 7 -> both data outputs 0, `reg_stall` 0, `reg_pending` 0x00000000.
- **Writeback and x0:**
  - Writeback addr 3, data 0xDEADBEEF00000001 -> next cycle `addr_a` = 3 reads 0xDEADBEEF00000001.
  - Writeback addr 0, data all-ones -> `addr_a` = 0 reads 0.
- **RAW stall:**
  - Issue `dest` = 4 with write enable -> `reg_pending[4]` = 1 next cycle.
  - Next instruction with `addr_b` = 4 -> `reg_stall` = 1 until writeback to addr 4 with data 0x55.
  - Without bypass: stall drops the cycle after the writeback and `data_b` = 0x55.
  - With bypass: stall drops in the writeback cycle and `data_b` = 0x55 in that same cycle.
- **WAW:** `reg_pending[9]` = 1, issue with `dest` = 9 and write enable -> `reg_stall` = 1. The same issue with write enable 0 -> `reg_stall` = 0.
- **Set/clear collision (bypass only):** `busy[6]` = 1, then writeback to 6 and an issue with `dest` = 6 in the same cycle -> no stall, and `reg_pending[6]` remains 1 afterwards.
- **Reset mid-operation:** `reg_pending` = 0x00000210 and register 3 nonzero, assert `reset` = 0 between edges -> `reg_pending` = 0 and `data_a` = 0 (for `addr_a` = 3) immediately.

Source files
------------

// File: rtl/vi_core_pkg.sv
// Shared core constants and typedefs for the integer register stage.
package vi_core_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] xlen_data_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/int_regfile_sb_scoreboard.sv
// Pending-write scoreboard: busy vector, set/clear priority and stall generation.
// Hazard masks come from the top so the forwarding policy lives in one place.
module int_scoreboard #(
  parameter int ADDR_W = vi_core_pkg::ADDR_W,
  parameter int NREGS  = vi_core_pkg::NREGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] dest,
  input  logic              write_enable,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              mask_a,
  input  logic              mask_b,
  input  logic              mask_w,
  output logic              stall,
  output logic [NREGS-1:0]  busy
);
  import vi_core_pkg::*;

  logic             haz_a;
  logic             haz_b;
  logic             haz_w;
  logic             issue_accept;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    haz_a        = busy[addr_a] && (addr_a != ZERO_REG) && !mask_a;
    haz_b        = busy[addr_b] && (addr_b != ZERO_REG) && !mask_b;
    haz_w        = write_enable && busy[dest] && (dest != ZERO_REG) && !mask_w;
    stall        = issue_valid && (haz_a || haz_b || haz_w);
    issue_accept = issue_valid && !stall;

    set_vec = '0;
    clr_vec = '0;
    if (issue_accept && write_enable && (dest != ZERO_REG)) set_vec[dest] = 1'b1;
    if (wb_enable && (wb_addr != ZERO_REG))                 clr_vec[wb_addr] = 1'b1;

    // Set applied after clear: a new producer in flight outranks the retiring one.
    busy_next    = (busy & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/int_regfile_sb.sv
// Integer register file with pending-write scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks and mask the matching hazards.
module int_regfile_sb #(
  parameter int DATA_W = vi_core_pkg::DATA_W,
  parameter int ADDR_W = vi_core_pkg::ADDR_W,
  parameter int NREGS  = vi_core_pkg::NREGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_issue_valid,
  input  logic [ADDR_W-1:0] reg_read_addr_a,
  input  logic [ADDR_W-1:0] reg_read_addr_b,
  input  logic [ADDR_W-1:0] reg_write_addr,
  input  logic              reg_int_write_enable,
  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] reg_int_data_a,
  output logic [DATA_W-1:0] reg_int_data_b,
  output logic              reg_stall,
  output logic [NREGS-1:0]  reg_pending
);
  import vi_core_pkg::*;

  logic [DATA_W-1:0] regs [NREGS];
  logic              fwd_a;
  logic              fwd_b;
  logic              fwd_w;

  // NOTE: the array takes the async reset because reset must clear contents immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_write_enable && (wb_write_addr != ZERO_REG)) begin
      regs[wb_write_addr] <= wb_write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = wb_write_enable && (wb_write_addr == reg_read_addr_a) && (reg_read_addr_a != ZERO_REG);
  assign fwd_b = wb_write_enable && (wb_write_addr == reg_read_addr_b) && (reg_read_addr_b != ZERO_REG);
  assign fwd_w = wb_write_enable && (wb_write_addr == reg_write_addr)  && (reg_write_addr  != ZERO_REG);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
  assign fwd_w = 1'b0;
`endif

  always_comb begin
    reg_int_data_a = '0;
    reg_int_data_b = '0;
    if (reg_read_addr_a != ZERO_REG) reg_int_data_a = regs[reg_read_addr_a];
    if (reg_read_addr_b != ZERO_REG) reg_int_data_b = regs[reg_read_addr_b];
    if (fwd_a) reg_int_data_a = wb_write_data;
    if (fwd_b) reg_int_data_b = wb_write_data;
  end

  int_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (reg_issue_valid),
    .addr_a       (reg_read_addr_a),
    .addr_b       (reg_read_addr_b),
    .dest         (reg_write_addr),
    .write_enable (reg_int_write_enable),
    .wb_enable    (wb_write_enable),
    .wb_addr      (wb_write_addr),
    .mask_a       (fwd_a),
    .mask_b       (fwd_b),
    .mask_w       (fwd_w),
    .stall        (reg_stall),
    .busy         (reg_pending)
  );

endmodule

// File: tb/tb_int_regfile_sb.sv
// Self-checking bench for int_regfile_sb: reference model plus directed literal checks.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_int_regfile_sb;
  import vi_core_pkg::*;

  logic       clock;
  logic       reset;
  logic       reg_issue_valid;
  reg_addr_t  reg_read_addr_a;
  reg_addr_t  reg_read_addr_b;
  reg_addr_t  reg_write_addr;
  logic       reg_int_write_enable;
  logic       wb_write_enable;
  reg_addr_t  wb_write_addr;
  xlen_data_t wb_write_data;
  xlen_data_t reg_int_data_a;
  xlen_data_t reg_int_data_b;
  logic       reg_stall;
  logic [NREGS-1:0] reg_pending;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks;
  int errors;
  bit compare_on;

  int_regfile_sb dut (
    .clock                (clock),
    .reset                (reset),
    .reg_issue_valid      (reg_issue_valid),
    .reg_read_addr_a      (reg_read_addr_a),
    .reg_read_addr_b      (reg_read_addr_b),
    .reg_write_addr       (reg_write_addr),
    .reg_int_write_enable (reg_int_write_enable),
    .wb_write_enable      (wb_write_enable),
    .wb_write_addr        (wb_write_addr),
    .wb_write_data        (wb_write_data),
    .reg_int_data_a       (reg_int_data_a),
    .reg_int_data_b       (reg_int_data_b),
    .reg_stall            (reg_stall),
    .reg_pending          (reg_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents and the set of registers awaiting writeback.
  xlen_data_t       mdl_regs [NREGS];
  logic [NREGS-1:0] mdl_busy;

  function automatic bool_forwarded(input reg_addr_t a);
    return BYPASS && wb_write_enable && (wb_write_addr == a) && (a != 0);
  endfunction

  function automatic xlen_data_t mdl_read(input reg_addr_t a);
    if (a == 0)            return '0;
    if (bool_forwarded(a)) return wb_write_data;
    return mdl_regs[a];
  endfunction

  function automatic logic mdl_waits_on(input reg_addr_t a);
    return (a != 0) && mdl_busy[a] && !bool_forwarded(a);
  endfunction

  function automatic logic mdl_stall();
    if (!reg_issue_valid) return 1'b0;
    return mdl_waits_on(reg_read_addr_a) || mdl_waits_on(reg_read_addr_b) ||
           (reg_int_write_enable && mdl_waits_on(reg_write_addr));
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mdl_regs[i] <= '0;
      mdl_busy <= '0;
    end else begin
      if (wb_write_enable && wb_write_addr != 0) begin
        mdl_regs[wb_write_addr] <= wb_write_data;
        mdl_busy[wb_write_addr] <= 1'b0;
      end
      // Later non-blocking write wins: a newly issued producer keeps the register busy.
      if (reg_issue_valid && !mdl_stall() && reg_int_write_enable && reg_write_addr != 0)
        mdl_busy[reg_write_addr] <= 1'b1;
    end
  end

  always @(negedge clock) begin
    if (compare_on) begin
      check("cmp_data_a",  reg_int_data_a, mdl_read(reg_read_addr_a));
      check("cmp_data_b",  reg_int_data_b, mdl_read(reg_read_addr_b));
      check("cmp_stall",   64'(reg_stall), 64'(mdl_stall()));
      check("cmp_pending", 64'(reg_pending), 64'(mdl_busy));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reg_issue_valid      = 1'b0;
    reg_read_addr_a      = '0;
    reg_read_addr_b      = '0;
    reg_write_addr       = '0;
    reg_int_write_enable = 1'b0;
    wb_write_enable      = 1'b0;
    wb_write_addr        = '0;
    wb_write_data        = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    compare_on = 1'b0;
    idle();

    // Reset state
    reset = 1'b0;
    reg_read_addr_a = 5'd5;
    reg_read_addr_b = 5'd7;
    #2;
    check("rst_data_a",  reg_int_data_a, 64'h0);
    check("rst_data_b",  reg_int_data_b, 64'h0);
    check("rst_stall",   64'(reg_stall), 64'h0);
    check("rst_pending", 64'(reg_pending), 64'h0);
    step();
    reset = 1'b1;
    compare_on = 1'b1;
    step();

    // Writeback visible the following cycle
    wb_write_enable = 1'b1;
    wb_write_addr   = 5'd3;
    wb_write_data   = 64'hDEADBEEF00000001;
    step();
    idle();
    reg_read_addr_a = 5'd3;
    #1 check("wb3_read", reg_int_data_a, 64'hDEADBEEF00000001);

    // Write to x0 is discarded
    wb_write_enable = 1'b1;
    wb_write_addr   = 5'd0;
    wb_write_data   = '1;
    step();
    idle();
    #1 check("x0_read", reg_int_data_a, 64'h0);

    // RAW: producer to x4, consumer on source B
    reg_issue_valid      = 1'b1;
    reg_write_addr       = 5'd4;
    reg_int_write_enable = 1'b1;
    #1 check("prod4_stall", 64'(reg_stall), 64'h0);
    step();
    idle();
    #1 check("prod4_pending", 64'(reg_pending), 64'h10);
    reg_issue_valid = 1'b1;
    reg_read_addr_b = 5'd4;
    #1 check("raw_stall_0", 64'(reg_stall), 64'h1);
    step();
    #1 check("raw_stall_1", 64'(reg_stall), 64'h1);
    wb_write_enable = 1'b1;
    wb_write_addr   = 5'd4;
    wb_write_data   = 64'h55;
    #1;
    check("raw_wb_cycle_stall", 64'(reg_stall), BYPASS ? 64'h0 : 64'h1);
    if (BYPASS) check("raw_wb_cycle_data", reg_int_data_b, 64'h55);
    step();
    wb_write_enable = 1'b0;
    #1;
    check("raw_after_stall",   64'(reg_stall), 64'h0);
    check("raw_after_data",    reg_int_data_b, 64'h55);
    check("raw_after_pending", 64'(reg_pending), 64'h0);
    step();
    idle();

    // WAW on x9
    reg_issue_valid      = 1'b1;
    reg_write_addr       = 5'd9;
    reg_int_write_enable = 1'b1;
    step();
    #1 check("waw_stall", 64'(reg_stall), 64'h1);
    reg_int_write_enable = 1'b0;
    #1 check("waw_nowe_stall", 64'(reg_stall), 64'h0);
    step();
    idle();
    #1 check("waw_pending", 64'(reg_pending), 64'h200);

    // Set/clear collision on x6 (bypass only)
    if (BYPASS) begin
      reg_issue_valid      = 1'b1;
      reg_write_addr       = 5'd6;
      reg_int_write_enable = 1'b1;
      step();
      wb_write_enable = 1'b1;
      wb_write_addr   = 5'd6;
      wb_write_data   = 64'h66;
      #1 check("coll_stall", 64'(reg_stall), 64'h0);
      step();
      idle();
      #1 check("coll_pending", 64'(reg_pending), 64'h240);
      wb_write_enable = 1'b1;
      wb_write_addr   = 5'd6;
      wb_write_data   = 64'h67;
      step();
      idle();
    end

    // Build pending = 0x210, then reset between edges
    reg_issue_valid      = 1'b1;
    reg_write_addr       = 5'd4;
    reg_int_write_enable = 1'b1;
    step();
    idle();
    reg_read_addr_a = 5'd3;
    #1;
    check("pre_rst_pending", 64'(reg_pending), 64'h210);
    check("pre_rst_data_a",  reg_int_data_a, 64'hDEADBEEF00000001);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_pending", 64'(reg_pending), 64'h0);
    check("mid_rst_data_a",  reg_int_data_a, 64'h0);
    step();
    reset = 1'b1;
    step();

    // Late writeback after reset: data lands, no busy bit appears
    wb_write_enable = 1'b1;
    wb_write_addr   = 5'd9;
    wb_write_data   = 64'h1234;
    step();
    idle();
    reg_read_addr_a = 5'd9;
    #1;
    check("late_wb_data",    reg_int_data_a, 64'h1234);
    check("late_wb_pending", 64'(reg_pending), 64'h0);

    // Stall inactive without a valid instruction even with a busy source
    reg_issue_valid      = 1'b1;
    reg_write_addr       = 5'd12;
    reg_int_write_enable = 1'b1;
    step();
    idle();
    reg_read_addr_a = 5'd12;
    #1 check("novalid_stall", 64'(reg_stall), 64'h0);
    step();
    #1 check("novalid_pending", 64'(reg_pending), 64'h1000);
    step();

    compare_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
